// File: rtl/rx_buf_pkg.sv
// Shared definitions for the RX sample buffer writer: FSM encoding, packing
// word indices, sample width and block-size derivation.
package rx_buf_pkg;

    localparam int SAMPLE_W = 24;
    localparam int WORD_W   = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_W0   = 2'd1;
    localparam logic [1:0] ST_W1   = 2'd2;
    localparam logic [1:0] ST_W2   = 2'd3;

    typedef enum logic [1:0] {
        PK_W0 = 2'd0,
        PK_W1 = 2'd1,
        PK_W2 = 2'd2
    } pack_idx_e;

    // One sample occupies three 16-bit words.
    function automatic int blk_words(input int nrx, input int nsamps);
        return 3 * nrx * nsamps;
    endfunction

    function automatic int chan_w(input int nrx);
        return (nrx > 1) ? $clog2(nrx) : 1;
    endfunction

endpackage

// File: rtl/rx_buf_writer_if.sv
// Sample stream in, BRAM port-A write out. The slave view is the writer block.
interface rx_buf_writer_if
    import rx_buf_pkg::*;
#(
    parameter int NRX      = 4,
    parameter int ADDR_MSB = 11
);
    localparam int CHAN_W = chan_w(NRX);

    logic                       in_valid;
    logic                       in_ready;
    logic [CHAN_W-1:0]          in_chan;
    logic signed [SAMPLE_W-1:0] in_i;
    logic signed [SAMPLE_W-1:0] in_q;
    logic [ADDR_MSB:0]          addra;
    logic [WORD_W-1:0]          dina;
    logic                       wea;

    modport master (
        output in_valid, in_chan, in_i, in_q,
        input  in_ready, addra, dina, wea
    );

    modport slave (
        input  in_valid, in_chan, in_i, in_q,
        output in_ready, addra, dina, wea
    );

endinterface

// File: rtl/rx_blk_tracker.sv
// Tracks completed ping-pong halves: completion pulse, half id, running
// count, unacknowledged depth and the sticky overrun flag.
module rx_blk_tracker (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmpl,
    input  logic        cmpl_half,
    input  logic        cpu_ack,
    input  logic        clr_err,
    output logic        blk_done,
    output logic        blk_half,
    output logic [15:0] blk_count,
    output logic [1:0]  pending,
    output logic        overrun
);
    logic [1:0] pend_nxt;
    logic       ovr_set;

    // An ack coinciding with a completion consumes the new half's slot.
    always_comb begin
        pend_nxt = pending;
        ovr_set  = 1'b0;
        if (cmpl) begin
            if (pending == 2'd2)
                ovr_set = !cpu_ack;
            else if (!cpu_ack)
                pend_nxt = pending + 2'd1;
        end else if (cpu_ack && (pending != 2'd0)) begin
            pend_nxt = pending - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_done  <= 1'b0;
            blk_half  <= 1'b0;
            blk_count <= '0;
            pending   <= '0;
            overrun   <= 1'b0;
        end else begin
            blk_done <= cmpl;
            if (cmpl) begin
                blk_half  <= cmpl_half;
                blk_count <= blk_count + 16'd1;
            end
            pending <= pend_nxt;
            overrun <= ovr_set || (overrun && !clr_err);
        end
    end

endmodule

// File: rtl/rx_buf_writer.sv
// Packs 24-bit I/Q samples into three 16-bit BRAM words, walks a ping-pong
// buffer address and checks the channel interleave sequence.
module rx_buf_writer
    import rx_buf_pkg::*;
#(
    parameter int ADDR_MSB = 11,
    parameter int NRX      = 4,
    parameter int NSAMPS   = 170
) (
    input  logic           adc_clk,
    input  logic           rst,
    rx_buf_writer_if.slave bus,
    input  logic           cpu_ack,
    input  logic           clr_err,
    output logic           blk_done,
    output logic           blk_half,
    output logic [15:0]    blk_count,
    output logic [1:0]     pending,
    output logic           overrun,
    output logic           seq_err
);
    localparam int ADDR_W    = ADDR_MSB + 1;
    localparam int BLK_WORDS = blk_words(NRX, NSAMPS);
    localparam int CHAN_W    = chan_w(NRX);

    localparam logic [ADDR_W-1:0] LAST_LO   = ADDR_W'(BLK_WORDS - 1);
    localparam logic [ADDR_W-1:0] LAST_HI   = ADDR_W'(2 * BLK_WORDS - 1);
    localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(NRX - 1);

    if (2 * BLK_WORDS > (1 << ADDR_W)) begin : g_size_check
        $error("rx_buf_writer: two halves of %0d words do not fit the address space", BLK_WORDS);
    end

    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return (p == LAST_HI) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [CHAN_W-1:0] chan_inc(input logic [CHAN_W-1:0] c);
        return (c == LAST_CHAN) ? '0 : c + 1'b1;
    endfunction

    function automatic logic [WORD_W-1:0] pack_word(input pack_idx_e idx,
                                                    input logic signed [SAMPLE_W-1:0] si,
                                                    input logic signed [SAMPLE_W-1:0] sq);
        case (idx)
            PK_W0:   return si[15:0];
            PK_W1:   return sq[15:0];
            default: return {si[23:16], sq[23:16]};
        endcase
    endfunction

    logic [1:0]                 state;
    logic [ADDR_W-1:0]          wptr;
    logic [CHAN_W-1:0]          exp_chan;
    logic signed [SAMPLE_W-1:0] i_p0;
    logic signed [SAMPLE_W-1:0] q_p0;
    logic [ADDR_W-1:0]          addra_q;
    logic [WORD_W-1:0]          dina_q;
    logic                       wea_q;
    logic                       seq_err_q;

    logic              rdy;
    logic              accept;
    logic              chan_ok;
    logic              take;
    logic              wr_nxt;
    logic [WORD_W-1:0] word_nxt;
    logic              cmpl;
    logic              cmpl_half;

    assign rdy     = !rst && ((state == ST_IDLE) || (state == ST_W2));
    assign accept  = bus.in_valid && rdy;
    assign chan_ok = (bus.in_chan == exp_chan);
    // A mistagged channel-0 sample is still written; it restarts the sequence.
    assign take    = accept && (chan_ok || (bus.in_chan == '0));

    always_comb begin
        wr_nxt   = 1'b0;
        word_nxt = '0;
        if (take) begin
            wr_nxt   = 1'b1;
            word_nxt = pack_word(PK_W0, bus.in_i, bus.in_q);
        end else if (state == ST_W0) begin
            wr_nxt   = 1'b1;
            word_nxt = pack_word(PK_W1, i_p0, q_p0);
        end else if (state == ST_W1) begin
            wr_nxt   = 1'b1;
            word_nxt = pack_word(PK_W2, i_p0, q_p0);
        end
    end

    // Completion is seen while the half's last word is on the BRAM port.
    assign cmpl      = (state == ST_W2) && ((addra_q == LAST_LO) || (addra_q == LAST_HI));
    assign cmpl_half = (addra_q == LAST_HI);

    // p0: sample capture on accept
    always_ff @(posedge adc_clk) begin
        if (take) begin
            i_p0 <= bus.in_i;
            q_p0 <= bus.in_q;
        end
    end

    always_ff @(posedge adc_clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            wptr      <= '0;
            exp_chan  <= '0;
            addra_q   <= '0;
            dina_q    <= '0;
            wea_q     <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            case (state)
                ST_W0:   state <= ST_W1;
                ST_W1:   state <= ST_W2;
                default: state <= take ? ST_W0 : ST_IDLE;
            endcase

            wea_q <= wr_nxt;
            if (wr_nxt) begin
                addra_q <= wptr;
                dina_q  <= word_nxt;
                wptr    <= ptr_inc(wptr);
            end

            if (accept) begin
                if (chan_ok)
                    exp_chan <= chan_inc(exp_chan);
                else if (bus.in_chan == '0)
                    exp_chan <= chan_inc('0);
                else
                    exp_chan <= '0;
            end

            seq_err_q <= (accept && !chan_ok) || (seq_err_q && !clr_err);
        end
    end

    assign bus.in_ready = rdy;
    assign bus.addra    = addra_q;
    assign bus.dina     = dina_q;
    assign bus.wea      = wea_q;
    assign seq_err      = seq_err_q;

    rx_blk_tracker u_tracker (
        .clk       (adc_clk),
        .rst       (rst),
        .cmpl      (cmpl),
        .cmpl_half (cmpl_half),
        .cpu_ack   (cpu_ack),
        .clr_err   (clr_err),
        .blk_done  (blk_done),
        .blk_half  (blk_half),
        .blk_count (blk_count),
        .pending   (pending),
        .overrun   (overrun)
    );

endmodule

// File: tb/tb_rx_buf_writer.sv
// Bench for rx_buf_writer with NRX=2, NSAMPS=2 (12-word halves, 24-word buffer).
module tb_rx_buf_writer;

    typedef struct {
        logic [4:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic       half;
        int         cnt;
        logic [4:0] end_addr;
    } done_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_ack = 1'b0;
    logic        clr_err = 1'b0;
    logic        blk_done;
    logic        blk_half;
    logic [15:0] blk_count;
    logic [1:0]  pending;
    logic        overrun;
    logic        seq_err;

    int n_chk = 0;
    int n_err = 0;

    wr_t   exp_q[$];
    done_t done_q[$];
    int    m_wptr = 0;
    int    m_cnt = 0;
    logic  prev_wea = 1'b0;
    logic [4:0] prev_addr = '0;

    rx_buf_writer_if #(.NRX(2), .ADDR_MSB(4)) bus ();

    rx_buf_writer #(.ADDR_MSB(4), .NRX(2), .NSAMPS(2)) dut (
        .adc_clk   (clk),
        .rst       (rst),
        .bus       (bus),
        .cpu_ack   (cpu_ack),
        .clr_err   (clr_err),
        .blk_done  (blk_done),
        .blk_half  (blk_half),
        .blk_count (blk_count),
        .pending   (pending),
        .overrun   (overrun),
        .seq_err   (seq_err)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: every BRAM write and every completion pulse is popped here.
    always @(negedge clk) begin
        if (bus.wea === 1'b1) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL wr_unexpected: got write addra=%0d dina=%h, want no write", bus.addra, bus.dina);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (bus.addra !== e.addr || bus.dina !== e.data) begin
                    n_err++;
                    $display("FAIL wr_data: got addra=%0d dina=%h, want addra=%0d dina=%h",
                             bus.addra, bus.dina, e.addr, e.data);
                end
            end
        end
        if (blk_done === 1'b1) begin
            n_chk++;
            if (done_q.size() == 0) begin
                n_err++;
                $display("FAIL done_unexpected: got blk_done=1 count=%0d, want no completion", blk_count);
            end else begin
                done_t d;
                d = done_q.pop_front();
                if (blk_half !== d.half || blk_count !== d.cnt[15:0] || prev_wea !== 1'b1 || prev_addr !== d.end_addr) begin
                    n_err++;
                    $display("FAIL done_fields: got half=%0d count=%0d prev_wr=%0d@%0d, want half=%0d count=%0d prev_wr=1@%0d",
                             blk_half, blk_count, prev_wea, prev_addr, d.half, d.cnt, d.end_addr);
                end
            end
        end
        prev_wea  = bus.wea;
        prev_addr = bus.addra;
    end

    // Starts and ends on a falling edge; wr=0 means the sample must be dropped.
    task automatic send(input int ch, input logic [23:0] si, input logic [23:0] sq, input bit wr);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            n_chk++;
            n_err++;
            $display("FAIL ready_timeout: got in_ready=%b, want 1 within 20 cycles", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_chan  = 1'(ch);
        bus.in_i     = si;
        bus.in_q     = sq;
        if (wr) begin
            for (int k = 0; k < 3; k++) begin
                wr_t w;
                w.addr = 5'(m_wptr);
                w.data = (k == 0) ? si[15:0] : (k == 1) ? sq[15:0] : {si[23:16], sq[23:16]};
                exp_q.push_back(w);
                if (m_wptr == 11 || m_wptr == 23) begin
                    done_t d;
                    m_cnt++;
                    d.half     = (m_wptr == 23);
                    d.cnt      = m_cnt;
                    d.end_addr = 5'(m_wptr);
                    done_q.push_back(d);
                end
                m_wptr = (m_wptr == 23) ? 0 : m_wptr + 1;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_chk++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b, want 0", bus.in_ready); end
        n_chk++; if (bus.wea !== 1'b0 || bus.addra !== 5'd0 || bus.dina !== 16'h0) begin
            n_err++; $display("FAIL rst_bram: got wea=%b addra=%0d dina=%h, want 0 0 0", bus.wea, bus.addra, bus.dina); end
        n_chk++; if (blk_done !== 1'b0 || blk_half !== 1'b0 || blk_count !== 16'd0 || pending !== 2'd0) begin
            n_err++; $display("FAIL rst_blk: got done=%b half=%b count=%0d pending=%0d, want all 0", blk_done, blk_half, blk_count, pending); end
        n_chk++; if (overrun !== 1'b0 || seq_err !== 1'b0) begin
            n_err++; $display("FAIL rst_err: got overrun=%b seq_err=%b, want 0 0", overrun, seq_err); end
        rst = 1'b0;
        @(negedge clk);
        n_chk++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b, want 1", bus.in_ready); end
    endtask

    task automatic test_stream();
        send(0, 24'h123456, 24'hABCDEF, 1'b1);
        n_chk++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL ready_w0: got %b, want 0", bus.in_ready); end
        @(negedge clk);
        n_chk++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL ready_w1: got %b, want 0", bus.in_ready); end
        @(negedge clk);
        n_chk++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL ready_w2: got %b, want 1", bus.in_ready); end
        send(1, 24'h800001, 24'h7FFFFE, 1'b1);
        drain();
    endtask

    task automatic test_half_fill();
        send(0, 24'hFEDCBA, 24'h000000, 1'b1);
        send(1, $urandom, $urandom, 1'b1);
        drain();
        n_chk++; if (blk_count !== 16'd1 || pending !== 2'd1 || blk_half !== 1'b0) begin
            n_err++; $display("FAIL half0: got count=%0d pending=%0d half=%b, want 1 1 0", blk_count, pending, blk_half); end
        for (int s = 0; s < 4; s++) send(s % 2, $urandom, $urandom, 1'b1);
        drain();
        n_chk++; if (blk_count !== 16'd2 || pending !== 2'd2 || blk_half !== 1'b1 || overrun !== 1'b0) begin
            n_err++; $display("FAIL half1: got count=%0d pending=%0d half=%b ovr=%b, want 2 2 1 0", blk_count, pending, blk_half, overrun); end
    endtask

    task automatic test_overrun();
        for (int s = 0; s < 4; s++) send(s % 2, $urandom, $urandom, 1'b1);
        drain();
        n_chk++; if (pending !== 2'd2 || overrun !== 1'b1 || blk_count !== 16'd3) begin
            n_err++; $display("FAIL overrun_set: got pending=%0d ovr=%b count=%0d, want 2 1 3", pending, overrun, blk_count); end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        n_chk++; if (overrun !== 1'b0 || pending !== 2'd2) begin
            n_err++; $display("FAIL overrun_clr: got ovr=%b pending=%0d, want 0 2", overrun, pending); end
    endtask

    task automatic test_ack();
        int n = 0;
        cpu_ack = 1'b1;
        @(negedge clk);
        cpu_ack = 1'b0;
        n_chk++; if (pending !== 2'd1) begin n_err++; $display("FAIL ack_dec: got pending=%0d, want 1", pending); end
        for (int s = 0; s < 4; s++) send(s % 2, $urandom, $urandom, 1'b1);
        while (blk_done !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        n_chk++; if (n >= 10) begin n_err++; $display("FAIL done_timeout: got blk_done=%b, want 1 within 10 cycles", blk_done); end
        cpu_ack = 1'b1;
        @(negedge clk);
        cpu_ack = 1'b0;
        n_chk++; if (blk_done !== 1'b0 || pending !== 2'd1 || overrun !== 1'b0) begin
            n_err++; $display("FAIL ack_with_done: got done=%b pending=%0d ovr=%b, want 0 1 0", blk_done, pending, overrun); end
        cpu_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        cpu_ack = 1'b0;
        n_chk++; if (pending !== 2'd0) begin n_err++; $display("FAIL ack_at_zero: got pending=%0d, want 0", pending); end
        drain();
    endtask

    task automatic test_seq_err();
        send(0, 24'h111111, 24'h222222, 1'b1);
        send(1, 24'h333333, 24'h444444, 1'b1);
        send(1, 24'h555555, 24'h666666, 1'b0);
        n_chk++; if (seq_err !== 1'b1) begin n_err++; $display("FAIL seq_set: got seq_err=%b, want 1", seq_err); end
        send(1, 24'h777777, 24'h888888, 1'b0);
        send(0, 24'h999999, 24'hAAAAAA, 1'b1);
        send(1, 24'hBBBBBB, 24'hCCCCCC, 1'b1);
        drain();
        n_chk++; if (seq_err !== 1'b1) begin n_err++; $display("FAIL seq_sticky: got seq_err=%b, want 1", seq_err); end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        n_chk++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL seq_clr: got seq_err=%b, want 0", seq_err); end
    endtask

    task automatic test_reset_mid();
        send(0, 24'hC0FFEE, 24'hBADF00, 1'b1);
        @(negedge clk);
        #1;
        void'(exp_q.pop_back());
        rst = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.wea !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_err++; $display("FAIL mid_rst: got wea=%b in_ready=%b, want 0 0", bus.wea, bus.in_ready); end
        rst = 1'b0;
        m_wptr = 0;
        m_cnt  = 0;
        done_q.delete();
        n_chk++; if (blk_count !== 16'd0 || pending !== 2'd0) begin
            n_err++; $display("FAIL mid_rst_blk: got count=%0d pending=%0d, want 0 0", blk_count, pending); end
        send(0, 24'h0A0B0C, 24'hF0E0D0, 1'b1);
        drain();
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_chan  = '0;
        bus.in_i     = '0;
        bus.in_q     = '0;
        test_reset();
        test_stream();
        test_half_fill();
        test_overrun();
        test_ack();
        test_seq_err();
        test_reset_mid();
        n_chk++; if (exp_q.size() != 0 || done_q.size() != 0) begin
            n_err++; $display("FAIL leftover: got %0d writes %0d completions outstanding, want 0 0", exp_q.size(), done_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/rx_buf_writer.md
# rx_buf_writer

Packs the per-channel 24-bit I/Q sample stream from the receiver channel mux into 16-bit words for the dual-port RX sample BRAM. It generates the port-A address, write data and write enable. The buffer is managed as two ping-pong halves. When a half fills, the block reports it to the CPU side and tracks unacknowledged halves to detect overrun.

## Interface
- `ADDR_MSB`, required: MSB of the BRAM port-A address; must equal the buffer's `ADDR_MSB`.
- `NRX`, 4: number of receiver channels interleaved in the input stream.
- `NSAMPS`, 170: samples per channel per half-buffer.
- Constraint: 2·`BLK_WORDS` ≤ 2^(`ADDR_MSB`+1), where `BLK_WORDS` = 3·`NRX`·`NSAMPS`. Elaboration fails otherwise.
- `adc_clk` input 1: the single clock. The BRAM `clka` is tied to it.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: sample valid.
- `in_ready` output 1: block accepts a sample this cycle.
- `in_chan` input clog2(`NRX`): channel tag of the sample.
- `in_i` input 24: I sample, two's complement.
- `in_q` input 24: Q sample, two's complement.
- `addra` output `ADDR_MSB`+1: BRAM write address.
- `dina` output 16: BRAM write data.
- `wea` output 1: BRAM write enable.
- `blk_done` output 1: one-cycle pulse when a half completes.
- `blk_half` output 1: half just completed (0 = low half, 1 = high half); held until the next completion.
- `blk_count` output 16: completed halves since reset; wraps modulo 2^16.
- `cpu_ack` input 1: one-cycle pulse; the CPU has consumed the oldest pending half.
- `pending` output 2: completed halves not yet acknowledged (0..2).
- `overrun` output 1: sticky; a half completed while `pending` = 2.
- `seq_err` output 1: sticky; a channel tag arrived out of sequence.
- `clr_err` input 1: clears `overrun` and `seq_err`.

## Operation
- **FSM states:** IDLE, W0, W1, W2.
  - `in_ready` = 1 in IDLE and W2, else 0.
  - An accept (`in_valid` & `in_ready`) latches `in_i`/`in_q` and moves to W0. Otherwise IDLE stays IDLE and W2 goes to IDLE.
  - W0 → W1 → W2 unconditionally.
- **Word packing**, `wea` = 1 in W0..W2:
  - W0: `dina` = `in_i[15:0]`.
  - W1: `dina` = `in_q[15:0]`.
  - W2: `dina` = {`in_i[23:16]`, `in_q[23:16]`}.
- **Address:**
  - `wptr` increments after every write.
  - On the write at `wptr` = 2·`BLK_WORDS`−1, `wptr` wraps to 0.
  - `addra` = `wptr` (zero-extended).
- **Channel sequencing:**
  - `exp_chan` starts at 0 and increments modulo `NRX` per accepted sample.
  - If an accepted sample has `in_chan` ≠ `exp_chan`, set `seq_err`.
    - If `in_chan` = 0, the sample is written and `exp_chan` becomes 1.
    - Otherwise the sample is dropped (FSM stays, no writes) and `exp_chan` is forced to 0. Resync happens on the next channel-0 sample.
- **Block completion:** after the W2 write that ends a half (`wptr` = `BLK_WORDS`−1 or 2·`BLK_WORDS`−1):
  - `blk_done` = 1 for one cycle.
  - `blk_half` = that half.
  - `blk_count` += 1.
  - `pending` += 1, saturating at 2. If `pending` was already 2, set `overrun`.
- **Acknowledge:**
  - `cpu_ack` with `pending` > 0 decrements `pending`. `cpu_ack` at 0 is ignored.
  - `cpu_ack` in the same cycle as a completion:
    - If `pending` < 2: net `pending` unchanged.
    - If `pending` = 2: stays 2, no overrun.
- **Error clear:** `clr_err` in the same cycle as a new error event leaves the flag set (the set wins).

## Timing
- **Reset values:**
  - FSM = IDLE, `wptr` = 0, `exp_chan` = 0.
  - `in_ready` = 0 while `rst` is asserted; 1 in the first cycle after.
  - `wea` = 0, `addra` = 0, `dina` = 0.
  - `blk_done` = 0, `blk_half` = 0, `blk_count` = 0, `pending` = 0.
  - `overrun` = 0, `seq_err` = 0.
- **Reset mid-operation:** a partial sample triplet is abandoned. The next sample is written at address 0.
- **Latency:** accept at cycle t; writes at t+1 (W0), t+2 (W1), t+3 (W2).
- **Throughput:** the next accept is possible at t+3, so back-to-back samples sustain 1 sample per 3 cycles with `wea` continuously high.
- **Completion:** `blk_done` is asserted at t+4 relative to the accept of the half's last sample; `blk_count`, `pending` and `blk_half` update in the same cycle.
- **Output registration:** all outputs are registered, except `in_ready`, which is decoded from the FSM state.

## Structure
- **Shared package `rx_buf_pkg`:**
  - FSM state enum.
  - Packing word indices W0/W1/W2.
  - Sample width constant (24).
  - `BLK_WORDS` derivation function.
- **Sub-module `rx_blk_tracker`:** owns `pending`, `overrun`, `blk_count`, `blk_half`. Inputs: completion strobe, completed half, `cpu_ack`, `clr_err`.
- **Top level:** FSM, packing, address and sequence check.

## Test plan
1. **Reset then steady stream.** `NRX`=2, `NSAMPS`=2, ch0 I=0x123456, Q=0xABCDEF → writes at addra 0,1,2: 0x3456, 0xCDEF, 0x12AB. `in_ready` is low for 2 of every 3 cycles.
2. **Half fill.** 4 samples (`BLK_WORDS`=12) → `blk_done` pulses once, 1 cycle after the write at addra 11, with `blk_half`=0, `blk_count`=1, `pending`=1. The 8th sample ends at addra 23, then `wptr` wraps to 0 and `blk_half`=1.
3. **Overrun.** 3 halves with no `cpu_ack` → `pending`=2 and `overrun`=1 after the third. `clr_err` clears `overrun`; `pending` stays 2.
4. **Simultaneous ack and completion.** `pending`=1, `cpu_ack` in the `blk_done` cycle → `pending` stays 1, `overrun`=0. At `pending`=0 with no completion, `cpu_ack` leaves it at 0.
5. **Sequence error.**
   - Tags 0,1,1 → third sample dropped (no `wea`), `seq_err`=1.
   - Next tag 1 → dropped.
   - Next tag 0 → written at the next address.
6. **Reset mid-triplet.** Assert `rst` in W1 → `wea`=0 the next cycle. The next accepted sample writes at addra 0, with `blk_count`=0.
